// File: rtl/flu_port_scheduler_pkg.sv
// Shared types for the FLU writeback-port scheduler: unit classes, writeback
// sources, the reservation-window entry and the scheduler FSM states.
package flu_port_scheduler_pkg;

   localparam int TRANS_ID_BITS = 3;

   typedef enum logic [1:0] {
      FC_ALU  = 2'd0,
      FC_CSR  = 2'd1,
      FC_MULT = 2'd2,
      FC_DIV  = 2'd3
   } fu_class_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_CSR  = 2'd1,
      WB_MULT = 2'd2,
      WB_DIV  = 2'd3
   } wb_src_t;

   typedef struct packed {
      logic                     v;
      logic [TRANS_ID_BITS-1:0] id;
   } flu_resv_t;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_DIV_WAIT = 1'b1
   } sched_state_t;

   // ALU and CSR results use the write port in the cycle they are granted.
   function automatic logic is_same_cycle_wb(input fu_class_t fu);
      return (fu == FC_ALU) || (fu == FC_CSR);
   endfunction

endpackage

// File: rtl/flu_port_scheduler_chk.sv
// Runtime check that at most one unit claims the FLU write port per cycle.
module flu_port_scheduler_chk (
   input logic clk_i,
   input logic rst_i,
   input logic src_mult_i,
   input logic src_div_i,
   input logic src_fire_i
);

   a_one_wb_src: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0({src_mult_i, src_div_i, src_fire_i}));

endmodule

// File: rtl/flu_resv_shreg.sv
// Writeback reservation window: entry k is the result due k cycles from now.
// Entries only move towards the head, so the load slot is always free.
module flu_resv_shreg
   import flu_port_scheduler_pkg::*;
#(
   parameter int MAX_LAT  = 4,
   parameter int LOAD_IDX = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     load_i,
   input  logic [TRANS_ID_BITS-1:0] load_id_i,
   output flu_resv_t                head_o,
   output logic                     any_v_o
);

   flu_resv_t r_resv [MAX_LAT];
   logic      w_any_v;

   // Shift towards the head every cycle; flush empties the whole window.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < MAX_LAT; k++) begin
            r_resv[k] <= '0;
         end
      end else if (clr_i) begin
         for (int k = 0; k < MAX_LAT; k++) begin
            r_resv[k] <= '0;
         end
      end else begin
         for (int k = 0; k < MAX_LAT - 1; k++) begin
            r_resv[k] <= r_resv[k+1];
         end
         r_resv[MAX_LAT-1] <= '0;
         if (load_i) begin
            r_resv[LOAD_IDX] <= '{v: 1'b1, id: load_id_i};
         end else begin
            r_resv[LOAD_IDX] <= (LOAD_IDX < MAX_LAT - 1) ? r_resv[LOAD_IDX+1] : '0;
         end
      end
   end

   // Any outstanding reservation anywhere in the window.
   always_comb begin
      w_any_v = 1'b0;
      for (int k = 0; k < MAX_LAT; k++) begin
         w_any_v = w_any_v | r_resv[k].v;
      end
   end

   assign head_o  = r_resv[0];
   assign any_v_o = w_any_v;

endmodule

// File: rtl/flu_port_scheduler.sv
// Issue-side scheduler for the shared fixed-latency-unit writeback port:
// grants ALU/CSR/MULT/DIV ops so that no two results hit the port together.
module flu_port_scheduler
   import flu_port_scheduler_pkg::*;
#(
   parameter int TRANS_ID_W = TRANS_ID_BITS,
   parameter int MULT_LAT   = 2,
   parameter int MAX_LAT    = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  issue_valid_i,
   input  logic [1:0]            issue_fu_i,
   input  logic [TRANS_ID_W-1:0] issue_trans_id_i,
   output logic                  issue_ready_o,
   output logic                  alu_valid_o,
   output logic                  csr_valid_o,
   output logic                  mult_valid_o,
   output logic                  div_valid_o,
   input  logic                  csr_ready_i,
   input  logic                  div_done_i,
   input  logic [TRANS_ID_W-1:0] div_trans_id_i,
   output logic                  wb_valid_o,
   output logic [TRANS_ID_W-1:0] wb_trans_id_o,
   output logic [1:0]            wb_src_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   sched_state_t    r_state;
   sched_state_t    w_state_nxt;
   fu_class_t       w_fu;
   flu_resv_t       w_head;
   logic            w_any_v;
   logic            w_ready;
   logic            w_fire;
   logic            w_src_mult;
   logic            w_src_div;
   logic            w_src_fire;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_fu = fu_class_t'(issue_fu_i);

   flu_resv_shreg #(
      .MAX_LAT  (MAX_LAT),
      .LOAD_IDX (MULT_LAT - 1)
   ) u_resv (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (flush_i),
      .load_i    (w_fire && (w_fu == FC_MULT)),
      .load_id_i (issue_trans_id_i),
      .head_o    (w_head),
      .any_v_o   (w_any_v)
   );

   // Grant: same-cycle writebacks need a free head slot, DIV needs an empty window.
   always_comb begin
      w_ready = 1'b0;
      if (flush_i) begin
         w_ready = 1'b0;
      end else if (r_state == ST_RUN) begin
         case (w_fu)
            FC_ALU:  w_ready = ~w_head.v;
            FC_CSR:  w_ready = ~w_head.v & csr_ready_i;
            FC_MULT: w_ready = 1'b1;
            FC_DIV:  w_ready = ~w_any_v & csr_ready_i;
            default: w_ready = 1'b0;
         endcase
      end else begin
         w_ready = 1'b0;
      end
   end

   assign w_fire        = issue_valid_i & w_ready;
   assign issue_ready_o = w_ready;
   assign alu_valid_o   = w_fire & (w_fu == FC_ALU);
   assign csr_valid_o   = w_fire & (w_fu == FC_CSR);
   assign mult_valid_o  = w_fire & (w_fu == FC_MULT);
   assign div_valid_o   = w_fire & (w_fu == FC_DIV);
   assign busy_o        = w_any_v | (r_state == ST_DIV_WAIT);

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: a DIV holds the port until its result comes back.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_fire && (w_fu == FC_DIV)) begin
               w_state_nxt = ST_DIV_WAIT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DIV_WAIT: begin
            if (flush_i || div_done_i) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_DIV_WAIT;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   assign w_src_mult = w_head.v;
   assign w_src_div  = (r_state == ST_DIV_WAIT) & div_done_i;
   assign w_src_fire = w_fire & is_same_cycle_wb(w_fu);

   // Writeback mux; a flush suppresses every source in its cycle.
   always_comb begin
      wb_valid_o    = 1'b0;
      wb_trans_id_o = '0;
      wb_src_o      = WB_ALU;
      if (flush_i) begin
         wb_valid_o = 1'b0;
      end else if (w_src_mult) begin
         wb_valid_o    = 1'b1;
         wb_trans_id_o = w_head.id;
         wb_src_o      = WB_MULT;
      end else if (w_src_div) begin
         wb_valid_o    = 1'b1;
         wb_trans_id_o = div_trans_id_i;
         wb_src_o      = WB_DIV;
      end else if (w_src_fire) begin
         wb_valid_o    = 1'b1;
         wb_trans_id_o = issue_trans_id_i;
         wb_src_o      = (w_fu == FC_CSR) ? WB_CSR : WB_ALU;
      end else begin
         wb_valid_o = 1'b0;
      end
   end

   // Saturating stall counter; only reset clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
      end else if (issue_valid_i && !w_ready && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign stall_cnt_o = r_stall_cnt;

   flu_port_scheduler_chk u_chk (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_mult_i (w_src_mult),
      .src_div_i  (w_src_div),
      .src_fire_i (w_src_fire)
   );

endmodule

// File: tb/tb_flu_port_scheduler.sv
// Directed bench for flu_port_scheduler with hand-computed expectations.
module tb_flu_port_scheduler;

   localparam int TW = 3;
   localparam int CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          issue_valid_i = 1'b0;
   logic [1:0]    issue_fu_i = 2'd0;
   logic [TW-1:0] issue_trans_id_i = 3'd0;
   logic          csr_ready_i = 1'b1;
   logic          div_done_i = 1'b0;
   logic [TW-1:0] div_trans_id_i = 3'd0;
   logic          issue_ready_o;
   logic          alu_valid_o;
   logic          csr_valid_o;
   logic          mult_valid_o;
   logic          div_valid_o;
   logic          wb_valid_o;
   logic [TW-1:0] wb_trans_id_o;
   logic [1:0]    wb_src_o;
   logic          busy_o;
   logic [CW-1:0] stall_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   flu_port_scheduler #(
      .TRANS_ID_W (TW),
      .MULT_LAT   (2),
      .MAX_LAT    (4),
      .CNT_W      (CW)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .flush_i          (flush_i),
      .issue_valid_i    (issue_valid_i),
      .issue_fu_i       (issue_fu_i),
      .issue_trans_id_i (issue_trans_id_i),
      .issue_ready_o    (issue_ready_o),
      .alu_valid_o      (alu_valid_o),
      .csr_valid_o      (csr_valid_o),
      .mult_valid_o     (mult_valid_o),
      .div_valid_o      (div_valid_o),
      .csr_ready_i      (csr_ready_i),
      .div_done_i       (div_done_i),
      .div_trans_id_i   (div_trans_id_i),
      .wb_valid_o       (wb_valid_o),
      .wb_trans_id_o    (wb_trans_id_o),
      .wb_src_o         (wb_src_o),
      .busy_o           (busy_o),
      .stall_cnt_o      (stall_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input logic v, input logic [TW-1:0] id, input logic [1:0] src);
      chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'(v));
      if (v) begin
         chk({tag, "_wb_id"}, 32'(wb_trans_id_o), 32'(id));
         chk({tag, "_wb_src"}, 32'(wb_src_o), 32'(src));
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic req(input logic v, input logic [1:0] fu, input logic [TW-1:0] id);
      issue_valid_i    = v;
      issue_fu_i       = fu;
      issue_trans_id_i = id;
   endtask

   initial begin
      // reset state
      cyc(); cyc(); settle();
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_stall", 32'(stall_cnt_o), 32'd0);
      chk("rst_strobes", 32'({alu_valid_o, csr_valid_o, mult_valid_o, div_valid_o}), 32'd0);
      cyc(); rst_i = 1'b0;

      // ALU every cycle: same-cycle writeback, never stalls
      for (int i = 1; i <= 3; i++) begin
         cyc(); req(1'b1, 2'd0, 3'(i)); settle();
         chk("alu_ready", 32'(issue_ready_o), 32'd1);
         chk("alu_strobe", 32'(alu_valid_o), 32'd1);
         chk_wb("alu", 1'b1, 3'(i), 2'd0);
      end
      chk("alu_stall", 32'(stall_cnt_o), 32'd0);

      // MULT id5 at t0, ALU id6 at t2 collides with the MULT result
      cyc(); req(1'b1, 2'd2, 3'd5); settle();
      chk("m2_mult_strobe", 32'(mult_valid_o), 32'd1);
      chk_wb("m2_t0", 1'b0, 3'd0, 2'd0);
      cyc(); req(1'b0, 2'd0, 3'd0); settle();
      chk("m2_busy", 32'(busy_o), 32'd1);
      chk_wb("m2_t1", 1'b0, 3'd0, 2'd0);
      cyc(); req(1'b1, 2'd0, 3'd6); settle();
      chk("m2_t2_ready", 32'(issue_ready_o), 32'd0);
      chk("m2_t2_alu", 32'(alu_valid_o), 32'd0);
      chk_wb("m2_t2", 1'b1, 3'd5, 2'd2);
      cyc(); settle();
      chk("m2_t3_stall", 32'(stall_cnt_o), 32'd1);
      chk("m2_t3_ready", 32'(issue_ready_o), 32'd1);
      chk_wb("m2_t3", 1'b1, 3'd6, 2'd0);
      chk("m2_t3_busy", 32'(busy_o), 32'd0);

      // CSR waits for csr_ready_i
      cyc(); csr_ready_i = 1'b0; req(1'b1, 2'd1, 3'd3); settle();
      chk("csr_blk_ready", 32'(issue_ready_o), 32'd0);
      chk("csr_blk_strobe", 32'(csr_valid_o), 32'd0);
      chk_wb("csr_blk", 1'b0, 3'd0, 2'd0);
      cyc(); csr_ready_i = 1'b1; settle();
      chk("csr_ready", 32'(issue_ready_o), 32'd1);
      chk("csr_strobe", 32'(csr_valid_o), 32'd1);
      chk_wb("csr", 1'b1, 3'd3, 2'd1);
      chk("csr_stall", 32'(stall_cnt_o), 32'd2);

      // back-to-back MULT ids 1,2,3
      for (int i = 1; i <= 3; i++) begin
         cyc(); req(1'b1, 2'd2, 3'(i)); settle();
         chk("m3_ready", 32'(issue_ready_o), 32'd1);
         chk_wb("m3_issue", i == 3, 3'd1, 2'd2);
      end
      cyc(); req(1'b0, 2'd0, 3'd0); settle();
      chk_wb("m3_t3", 1'b1, 3'd2, 2'd2);
      cyc(); settle();
      chk_wb("m3_t4", 1'b1, 3'd3, 2'd2);
      cyc(); settle();
      chk_wb("m3_t5", 1'b0, 3'd0, 2'd0);
      chk("m3_busy", 32'(busy_o), 32'd0);

      // DIV behind a pending MULT, then blocks all issue until done
      cyc(); req(1'b1, 2'd2, 3'd7); settle();
      chk("d_mult_strobe", 32'(mult_valid_o), 32'd1);
      cyc(); req(1'b1, 2'd3, 3'd4); settle();
      chk("d_t1_ready", 32'(issue_ready_o), 32'd0);
      chk("d_t1_div", 32'(div_valid_o), 32'd0);
      cyc(); settle();
      chk("d_t2_ready", 32'(issue_ready_o), 32'd0);
      chk_wb("d_t2", 1'b1, 3'd7, 2'd2);
      cyc(); settle();
      chk("d_t3_ready", 32'(issue_ready_o), 32'd1);
      chk("d_t3_div", 32'(div_valid_o), 32'd1);
      chk_wb("d_t3", 1'b0, 3'd0, 2'd0);
      chk("d_t3_stall", 32'(stall_cnt_o), 32'd4);
      cyc(); req(1'b1, 2'd0, 3'd2); settle();
      chk("d_t4_ready", 32'(issue_ready_o), 32'd0);
      chk("d_t4_alu", 32'(alu_valid_o), 32'd0);
      chk("d_t4_busy", 32'(busy_o), 32'd1);
      chk_wb("d_t4", 1'b0, 3'd0, 2'd0);
      cyc(); div_done_i = 1'b1; div_trans_id_i = 3'd4; settle();
      chk("d_t5_ready", 32'(issue_ready_o), 32'd0);
      chk_wb("d_t5", 1'b1, 3'd4, 2'd3);
      cyc(); div_done_i = 1'b0; settle();
      chk("d_t6_ready", 32'(issue_ready_o), 32'd1);
      chk_wb("d_t6", 1'b1, 3'd2, 2'd0);
      chk("d_t6_busy", 32'(busy_o), 32'd0);
      chk("d_t6_stall", 32'(stall_cnt_o), 32'd6);

      // flush kills an in-flight MULT
      cyc(); req(1'b1, 2'd2, 3'd6); settle();
      chk("f_mult_strobe", 32'(mult_valid_o), 32'd1);
      cyc(); flush_i = 1'b1; req(1'b1, 2'd0, 3'd1); settle();
      chk("f_t1_ready", 32'(issue_ready_o), 32'd0);
      chk("f_t1_alu", 32'(alu_valid_o), 32'd0);
      chk_wb("f_t1", 1'b0, 3'd0, 2'd0);
      cyc(); flush_i = 1'b0; req(1'b0, 2'd3, 3'd0); settle();
      chk_wb("f_t2", 1'b0, 3'd0, 2'd0);
      chk("f_t2_busy", 32'(busy_o), 32'd0);
      chk("f_t2_run", 32'(issue_ready_o), 32'd1);
      chk("f_t2_stall", 32'(stall_cnt_o), 32'd7);

      // reset while in DIV_WAIT; late div_done ignored
      cyc(); req(1'b1, 2'd3, 3'd5); settle();
      chk("r_div_strobe", 32'(div_valid_o), 32'd1);
      cyc(); req(1'b0, 2'd3, 3'd0); settle();
      chk("r_wait_busy", 32'(busy_o), 32'd1);
      chk("r_wait_ready", 32'(issue_ready_o), 32'd0);
      #1 rst_i = 1'b1;
      #1;
      chk("r_busy", 32'(busy_o), 32'd0);
      chk("r_stall", 32'(stall_cnt_o), 32'd0);
      chk("r_ready", 32'(issue_ready_o), 32'd1);
      chk_wb("r_rst", 1'b0, 3'd0, 2'd0);
      cyc(); rst_i = 1'b0;
      cyc(); div_done_i = 1'b1; div_trans_id_i = 3'd5; settle();
      chk_wb("r_late_done", 1'b0, 3'd0, 2'd0);
      chk("r_late_busy", 32'(busy_o), 32'd0);
      cyc(); div_done_i = 1'b0;

      // stall counter saturation
      csr_ready_i = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         cyc(); req(1'b1, 2'd1, 3'd0); settle();
         chk("sat_cnt", 32'(stall_cnt_o), (i > 15) ? 32'd15 : 32'(i));
      end
      cyc(); req(1'b0, 2'd0, 3'd0); settle();
      chk("sat_final", 32'(stall_cnt_o), 32'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
